// File: rtl/bcd_timer_ctrl_if.sv
// Button, load and digit signals shared between the BCD timer and its driver.
`default_nettype none

interface bcd_timer_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       mode_down;
  logic       load_en;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic [3:0] d_1;
  logic [3:0] d_2;
  logic       running;
  logic       done;

  modport master (
    output btn_start, btn_clear, mode_down, load_en, load_tens, load_ones,
    input  d_1, d_2, running, done
  );

  modport slave (
    input  btn_start, btn_clear, mode_down, load_en, load_tens, load_ones,
    output d_1, d_2, running, done
  );
endinterface

`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down seconds timer with start/pause, clear and load control.
`default_nettype none

module bcd_timer_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic             clk_in,
  input  logic             rst,
  bcd_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic start_s1_q, start_s2_q, start_s3_q;
  logic clear_s1_q, clear_s2_q;
  logic mode_s1_q, mode_s2_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      clear_s1_q <= 1'b0;
      clear_s2_q <= 1'b0;
      mode_s1_q  <= 1'b0;
      mode_s2_q  <= 1'b0;
    end else begin
      start_s1_q <= bus.btn_start;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      clear_s1_q <= bus.btn_clear;
      clear_s2_q <= clear_s1_q;
      mode_s1_q  <= bus.mode_down;
      mode_s2_q  <= mode_s1_q;
    end
  end

  logic start_evt, clear_req, count_down;
  assign start_evt  = start_s2_q & ~start_s3_q;
  assign clear_req  = clear_s2_q;
  assign count_down = mode_s2_q;

  state_t           state_q, state_d;
  logic [3:0]       ones_q, ones_d, tens_q, tens_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             running_q, running_d, done_q, done_d;

  logic       tick, at_max, at_min;
  logic [3:0] load_ones_clamp, load_tens_clamp;

  assign tick            = (presc_q == TICK_LAST);
  assign at_max          = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign at_min          = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign load_ones_clamp = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;
  assign load_tens_clamp = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    presc_d = presc_q;

    if (clear_req) begin
      state_d = ST_IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_en) begin
            ones_d = load_ones_clamp;
            tens_d = load_tens_clamp;
          end else if (start_evt) begin
            if ((count_down && at_min) || (!count_down && at_max)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              presc_d = '0;
            end
          end
        end

        ST_RUN: begin
          // On the pausing edge the prescaler keeps its phase unless it wraps.
          if (tick)           presc_d = '0;
          else if (!start_evt) presc_d = presc_q + CNT_W'(1);

          if (tick) begin
            if (count_down) begin
              if (at_min) begin
                state_d = ST_DONE;
              end else begin
                if (ones_q == 4'd0) begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
                end else begin
                  ones_d = ones_q - 4'd1;
                end
                if ((tens_q == 4'd0) && (ones_q == 4'd1)) state_d = ST_DONE;
              end
            end else begin
              if (at_max) begin
                state_d = ST_DONE;
              end else begin
                if (ones_q == 4'd9) begin
                  ones_d = 4'd0;
                  tens_d = tens_q + 4'd1;
                end else begin
                  ones_d = ones_q + 4'd1;
                end
                if ((tens_q == 4'd9) && (ones_q == 4'd8)) state_d = ST_DONE;
              end
            end
          end

          if (start_evt && (state_d == ST_RUN)) state_d = ST_PAUSE;
        end

        ST_PAUSE: begin
          if (start_evt) state_d = ST_RUN;
        end

        ST_DONE: begin
          if (start_evt) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.d_1     = ones_q;
  assign bus.d_2     = tens_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl: reference model predicts every cycle's outputs.
`default_nettype none

module tb_bcd_timer_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_timer_ctrl_if tif ();

  bcd_timer_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (tif)
  );

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  // Reference model: timer value held as a plain integer 0..99.
  initial begin : model
    int  mstate;   // 0 idle, 1 run, 2 pause, 3 done
    int  mval, mphase, lt, lo;
    bit  b1, b2, b3, c1, c2, m1, m2, evt, clr, dn;
    mstate = 0; mval = 0; mphase = 0;
    {b1, b2, b3, c1, c2, m1, m2} = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mstate = 0; mval = 0; mphase = 0;
        {b1, b2, b3, c1, c2, m1, m2} = '0;
        exp_q.delete();
      end else begin
        evt = b2 & ~b3;
        clr = c2;
        dn  = m2;
        if (clr) begin
          mstate = 0; mval = 0; mphase = 0;
        end else begin
          case (mstate)
            0: begin
              if (tif.load_en) begin
                lt = (tif.load_tens > 9) ? 9 : int'(tif.load_tens);
                lo = (tif.load_ones > 9) ? 9 : int'(tif.load_ones);
                mval = lt * 10 + lo;
              end else if (evt) begin
                if ((dn && mval == 0) || (!dn && mval == 99)) mstate = 3;
                else begin mstate = 1; mphase = 0; end
              end
            end
            1: begin
              if (mphase == TD - 1) begin
                mphase = 0;
                if (dn) begin
                  if (mval > 0) mval = mval - 1;
                  if (mval == 0) mstate = 3;
                end else begin
                  if (mval < 99) mval = mval + 1;
                  if (mval == 99) mstate = 3;
                end
              end else if (!evt) begin
                mphase = mphase + 1;
              end
              if (evt && mstate == 1) mstate = 2;
            end
            2: if (evt) mstate = 1;
            default: if (evt) mstate = 0;
          endcase
        end
        b3 = b2; b2 = b1; b1 = tif.btn_start;
        c2 = c1; c1 = tif.btn_clear;
        m2 = m1; m1 = tif.mode_down;
        exp_q.push_back({4'(mval / 10), 4'(mval % 10), mstate == 1, mstate == 3});
      end
    end
  end

  // Monitor: compares each registered output update, and the async reset response.
  initial begin : monitor
    logic [9:0] act, e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      act = {tif.d_2, tif.d_1, tif.running, tif.done};
      checks++;
      if (rst) begin
        if (act !== 10'd0) begin
          failures++;
          $display("FAIL reset_state t=%0t got=%h expected=%h", $time, act, 10'd0);
        end
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t got=%h", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t got d2=%0d d1=%0d run=%b done=%b expected d2=%0d d1=%0d run=%b done=%b",
                   $time, act[9:6], act[5:2], act[1], act[0], e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    tif.btn_start = 1'b1; step(3);
    tif.btn_start = 1'b0; step(3);
  endtask

  task automatic clear_pulse();
    tif.btn_clear = 1'b1; step(3);
    tif.btn_clear = 1'b0; step(2);
  endtask

  task automatic load(input logic [3:0] t, input logic [3:0] o);
    tif.load_en = 1'b1; tif.load_tens = t; tif.load_ones = o; step(1);
    tif.load_en = 1'b0; step(1);
  endtask

  initial begin
    tif.btn_start = 1'b0; tif.btn_clear = 1'b0; tif.mode_down = 1'b0;
    tif.load_en = 1'b0; tif.load_tens = 4'd0; tif.load_ones = 4'd0;
    step(3);
    rst = 1'b0;

    press(); step(45); clear_pulse();                 // up count from 00
    load(4'd9, 4'd8); press(); step(10); press();     // 98 -> 99 -> DONE -> IDLE
    tif.mode_down = 1'b1; step(3);
    load(4'd1, 4'd2); press(); step(60); press(); step(4);  // down 12 -> 00
    tif.mode_down = 1'b0; step(3); clear_pulse();
    tif.btn_start = 1'b1; step(4); tif.btn_start = 1'b0; step(3);  // start, then pause
    press(); step(20); press(); step(10);             // pause hold and resume
    clear_pulse();
    load(4'hF, 4'hA); step(2);                        // clamp to 99
    load(4'd2, 4'd0); press();
    load(4'd5, 4'd5); step(6); clear_pulse();         // load ignored while running
    tif.btn_clear = 1'b1; tif.btn_start = 1'b1; step(4);
    tif.btn_clear = 1'b0; tif.btn_start = 1'b0; step(4);
    tif.btn_start = 1'b1; step(2);                    // load coincident with start_evt
    tif.load_en = 1'b1; tif.load_tens = 4'd4; tif.load_ones = 4'd4; step(1);
    tif.load_en = 1'b0; step(1); tif.btn_start = 1'b0; step(4);
    clear_pulse(); tif.mode_down = 1'b1; step(3); press(); step(3);  // 00 down -> DONE
    press(); tif.mode_down = 1'b0; step(3);
    load(4'd3, 4'd7); press(); step(1);               // async reset mid-run at 37
    #2 rst = 1'b1;
    step(3);
    rst = 1'b0; step(5);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) tif.btn_start = ~tif.btn_start;
      if ($urandom_range(0, 31) == 0) tif.mode_down = ~tif.mode_down;
      tif.btn_clear = ($urandom_range(0, 79) == 0);
      tif.load_en   = ($urandom_range(0, 15) == 0);
      tif.load_tens = 4'($urandom_range(0, 15));
      tif.load_ones = 4'($urandom_range(0, 15));
    end
    tif.load_en = 1'b0;
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
